led_program_loader: RTL and testbench
=====================================

Name: led_program_loader

Overview:
- Sits directly upstream of the LED sequencer core and owns its 256x16 instruction memory.
- Each instruction word is {pattern[15:8], duration[7:0]}; duration 0 means jump to the address in [15:8].
- Accepts a framed byte stream from a UART receiver and writes it into memory, with checksum and inter-byte timeout.
- Holds the core in reset while a program is loading or invalid, and serves the core's asynchronous read port.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 5_000_000, maximum clk cycles between bytes inside a frame (100 ms at 50 MHz).
- ADDR_W, 8, instruction address width; depth = 2**ADDR_W.
- DATA_W, 16, instruction word width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- rd_addr  in  ADDR_W  core instruction fetch address.
- rd_data  out  DATA_W  instruction at rd_addr, combinational (asynchronous) read.
- core_rst  out  1  reset to the sequencer core.
- loading  out  1  high while a frame is in progress.
- load_ok  out  1  one-cycle pulse when a frame completes with a good checksum.
- load_err  out  1  sticky error flag; cleared by rst or by the next SYNC_BYTE accepted in S_IDLE.
- words_loaded  out  ADDR_W+1  word count of the last good frame (1..256).

Behaviour:
- Reset values:
  - Outputs: loading=0, load_ok=0, load_err=0, words_loaded=0.
  - Internal: FSM=S_IDLE, prog_valid=0, so core_rst=1.
  - Memory contents are not reset.
- core_rst = rst | loading | ~prog_valid. It is a registered output with one cycle of latency from its sources.
- Frame format: SYNC_BYTE, CNT, then N word pairs (HI, LO), then CHK.
  - N = CNT, except CNT=0 means N=256.
  - CHK = 8-bit mod-256 sum of all HI and LO bytes. CNT is not included.
- FSM states:
  - S_IDLE: rx_valid with rx_data==SYNC_BYTE goes to S_CNT. On that edge: loading=1, prog_valid=0, load_err=0. Other bytes are ignored.
  - S_CNT: latch N, clear wr_addr and the sum, go to S_HI.
  - S_HI: latch hi byte, add to sum, go to S_LO.
  - S_LO: write {hi, rx_data} to mem[wr_addr] on this edge and add rx_data to sum.
    - If the count is reached, go to S_CHK.
    - Otherwise wr_addr+1 and go to S_HI.
  - S_CHK:
    - On match: prog_valid=1, load_ok pulse, words_loaded=N, loading=0, go to S_IDLE.
    - On mismatch: load_err=1, loading=0, prog_valid stays 0, go to S_IDLE.
- Memory writes occur only in S_LO.
- Once a frame has started, every byte is data, including a byte equal to SYNC_BYTE. There is no resync mid-frame.
- Timeout: an idle counter resets on every rx_valid and runs only outside S_IDLE.
  - On reaching TIMEOUT_CYCLES: load_err=1, loading=0, prog_valid=0, go to S_IDLE.
  - Words already written remain in memory.
- Arithmetic:
  - The sum wraps mod 256.
  - The word counter is ADDR_W+1 bits so that N=256 terminates correctly.
  - wr_addr wraps only after the final word and is never used past it.
- Read/write collision: same address in the same cycle gives old data before the edge and new data after it. The core is in reset during loads, so no hazard exists.
- rst in mid-frame aborts to S_IDLE. Memory keeps any partial data, and prog_valid=0.
- A second SYNC_BYTE received while in S_IDLE after a good load starts a new frame. The core is held in reset immediately on the next cycle.

Decomposition:
- Shared package led_cpu_pkg:
  - ADDR_W, DATA_W, SYNC_BYTE.
  - FSM state encoding (S_IDLE, S_CNT, S_HI, S_LO, S_CHK).
  - Instruction field positions PAT_MSB/LSB and DUR_MSB/LSB, plus JUMP_DUR=0. The core uses the same package.
- One natural sub-module: led_instr_ram, 2**ADDR_W x DATA_W distributed RAM with one synchronous write port and one asynchronous read port.

Test Plan:
- Good load: reset, then A5 02 F0 04 00 00 F4.
  - Required: mem[0]=16'hF004, mem[1]=16'h0000.
  - load_ok pulses once; words_loaded=2; core_rst drops 1 cycle after the CHK byte.
  - rd_addr=1 returns 16'h0000.
- Bad checksum: A5 01 12 34 00.
  - Required: load_err=1, load_ok never pulses, core_rst stays 1, mem[0]=16'h1234.
- Timeout: A5 03 AA, then no rx_valid for TIMEOUT_CYCLES.
  - Required: load_err=1, loading=0, FSM back in S_IDLE.
  - A following good frame then succeeds and clears load_err.
- Full depth: CNT=00 with 256 pairs (HI=i, LO=~i) and a correct CHK.
  - Required: words_loaded=256, mem[255]=16'hFF00, no write wraps to address 0 after the last word.
- SYNC_BYTE as data and reset mid-frame:
  - A5 01 A5 A5 4A loads mem[0]=16'hA5A5 successfully.
  - Then A5 02 11 with rst asserted gives an S_IDLE abort, core_rst=1, and load_err=0.

Source files
------------

// File: rtl/led_cpu_pkg.sv
// led_cpu_pkg: constants, loader FSM encoding and instruction field layout shared by the loader and the sequencer core.
package led_cpu_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int PAT_MSB = 15;
    localparam int PAT_LSB = 8;
    localparam int DUR_MSB = 7;
    localparam int DUR_LSB = 0;
    localparam logic [7:0] JUMP_DUR = 8'h00;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_HI,
        S_LO,
        S_CHK
    } state_t;
endpackage

// File: rtl/led_instr_ram.sv
// led_instr_ram: 2**ADDR_W x DATA_W distributed RAM, one synchronous write port and one asynchronous read port.
module led_instr_ram
    import led_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/led_program_loader.sv
// led_program_loader: loads framed, checksummed UART byte streams into the instruction RAM and gates the sequencer core reset.
module led_program_loader
    import led_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              core_rst,
    output logic              loading,
    output logic              load_ok,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(2 ** ADDR_W);

    state_t          state_q, state_d;
    logic [ADDR_W:0] n_q, n_d, wcnt_q, wcnt_d, words_q, words_d;
    logic [7:0]      sum_q, sum_d, hi_q, hi_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            loading_q, loading_d, load_ok_q, load_ok_d, load_err_q, load_err_d;
    logic            prog_valid_q, prog_valid_d, core_rst_q, core_rst_d;
    logic            tmo_hit, last_word, we;

    assign tmo_hit   = state_q != S_IDLE && !rx_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign last_word = wcnt_q + (ADDR_W + 1)'(1) == n_q;
    assign we        = !rst && rx_valid && state_q == S_LO;

    always_ff @(posedge clk) begin
        n_q    <= n_d;
        wcnt_q <= wcnt_d;
        sum_q  <= sum_d;
        hi_q   <= hi_d;
        if (rst) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            loading_q    <= 1'b0;
            load_ok_q    <= 1'b0;
            load_err_q   <= 1'b0;
            prog_valid_q <= 1'b0;
            words_q      <= '0;
            core_rst_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            loading_q    <= loading_d;
            load_ok_q    <= load_ok_d;
            load_err_q   <= load_err_d;
            prog_valid_q <= prog_valid_d;
            words_q      <= words_d;
            core_rst_q   <= core_rst_d;
        end
    end

    // Once SYNC is accepted every byte is frame data; only the timeout or rst can abort.
    always_comb begin
        state_d = state_q;
        if (tmo_hit) state_d = S_IDLE;
        else if (rx_valid)
            case (state_q)
                S_IDLE:  state_d = rx_data == SYNC_BYTE ? S_CNT : S_IDLE;
                S_CNT:   state_d = S_HI;
                S_HI:    state_d = S_LO;
                S_LO:    state_d = last_word ? S_CHK : S_HI;
                default: state_d = S_IDLE;
            endcase
    end

    always_comb begin
        loading_d    = loading_q;
        load_ok_d    = 1'b0;
        load_err_d   = load_err_q;
        prog_valid_d = prog_valid_q;
        words_d      = words_q;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        sum_d        = sum_q;
        hi_d         = hi_q;
        tmo_d        = (rx_valid || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;
        core_rst_d   = loading_q || !prog_valid_q;
        if (tmo_hit) begin
            loading_d    = 1'b0;
            load_err_d   = 1'b1;
            prog_valid_d = 1'b0;
        end else if (rx_valid)
            case (state_q)
                S_IDLE: if (rx_data == SYNC_BYTE) begin
                    loading_d    = 1'b1;
                    prog_valid_d = 1'b0;
                    load_err_d   = 1'b0;
                end
                S_CNT: begin
                    n_d    = rx_data == 8'd0 ? DEPTH : (ADDR_W + 1)'(rx_data);
                    wcnt_d = '0;
                    sum_d  = '0;
                end
                S_HI: begin
                    hi_d  = rx_data;
                    sum_d = sum_q + rx_data;
                end
                S_LO: begin
                    sum_d  = sum_q + rx_data;
                    wcnt_d = last_word ? wcnt_q : wcnt_q + (ADDR_W + 1)'(1);
                end
                S_CHK: begin
                    loading_d    = 1'b0;
                    prog_valid_d = rx_data == sum_q;
                    load_ok_d    = rx_data == sum_q;
                    load_err_d   = rx_data != sum_q;
                    words_d      = rx_data == sum_q ? n_q : words_q;
                end
                default: ;
            endcase
    end

    led_instr_ram u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (wcnt_q[ADDR_W-1:0]),
        .wr_data ({hi_q, rx_data}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign core_rst     = core_rst_q;
    assign loading      = loading_q;
    assign load_ok      = load_ok_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_led_program_loader.sv
// tb_led_program_loader: frame-level reference model checked every cycle, plus literal expectations for the directed frames.
module tb_led_program_loader;
    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  rd_addr = 8'h00;
    logic [15:0] rd_data;
    logic        core_rst, loading, load_ok, load_err;
    logic [8:0]  words_loaded;

    led_program_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .core_rst     (core_rst),
        .loading      (loading),
        .load_ok      (load_ok),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    bit          m_loading, m_err, m_pv, m_ok, armed;
    bit          cr_exp = 1'b1;
    int          m_words, m_n, idx, since, ok_cnt, errors, checks;
    logic [7:0]  m_sum, m_hi;
    logic [15:0] m_mem [256];
    bit          m_known [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("core_rst", core_rst, cr_exp);
            chk("loading", loading, m_loading);
            chk("load_err", load_err, m_err);
            chk("load_ok", load_ok, m_ok);
            chk("words_loaded", words_loaded, m_words);
            if (m_known[rd_addr]) chk("rd_data", rd_data, m_mem[rd_addr]);
            if (load_ok) ok_cnt++;
        end
        m_ok = 1'b0;
        cr_exp = rst | m_loading | ~m_pv;
    end

    // Frame parser keyed on byte position since SYNC.
    task automatic parse(input logic [7:0] b);
        if (!m_loading) begin
            if (b == 8'hA5) begin
                m_loading = 1'b1; m_err = 1'b0; m_pv = 1'b0; idx = 1;
            end
        end else if (idx == 1) begin
            m_n = b == 8'd0 ? 256 : int'(b); m_sum = 8'd0; idx = 2;
        end else if (idx <= 2 * m_n + 1) begin
            m_sum = m_sum + b;
            if (idx % 2 == 0) m_hi = b;
            else begin
                m_mem[(idx - 3) / 2] = {m_hi, b};
                m_known[(idx - 3) / 2] = 1'b1;
            end
            idx++;
        end else begin
            m_loading = 1'b0;
            if (b == m_sum) begin
                m_pv = 1'b1; m_ok = 1'b1; m_words = m_n;
            end else m_err = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rd_addr++;
            since++;
            if (m_loading && since == T) begin
                m_loading = 1'b0; m_err = 1'b1; m_pv = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rd_addr++;
        since = 0;
        parse(b);
        idle(1);
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_loading = 1'b0; m_err = 1'b0; m_pv = 1'b0; m_ok = 1'b0; m_words = 0; since = 0;
        armed = 1'b1;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        do_reset();
        idle(3);
        chk("reset_core_rst", core_rst, 1);
        chk("reset_loading", loading, 0);
        chk("reset_load_err", load_err, 0);
        chk("reset_words", words_loaded, 0);
        send(8'h3C);
        send_list('{8'hA5, 8'h02, 8'hF0, 8'h04, 8'h00, 8'h00, 8'hF4});
        chk("good_core_rst", core_rst, 0);
        chk("good_words", words_loaded, 2);
        chk("good_ok_cnt", ok_cnt, 1);
        rd_check("good_mem0", 8'd0, 16'hF004);
        rd_check("good_mem1", 8'd1, 16'h0000);
        send_list('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00});
        idle(2);
        chk("bad_load_err", load_err, 1);
        chk("bad_core_rst", core_rst, 1);
        chk("bad_ok_cnt", ok_cnt, 1);
        rd_check("bad_mem0", 8'd0, 16'h1234);
        send_list('{8'hA5, 8'h03, 8'hAA});
        idle(T + 5);
        chk("tmo_load_err", load_err, 1);
        chk("tmo_loading", loading, 0);
        send_list('{8'hA5, 8'h01, 8'h56, 8'h78, 8'hCE});
        idle(2);
        chk("after_tmo_err", load_err, 0);
        chk("after_tmo_words", words_loaded, 1);
        chk("after_tmo_core_rst", core_rst, 0);
        rd_check("after_tmo_mem0", 8'd0, 16'h5678);
        send(8'hA5);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            send(~8'(i));
        end
        send(8'h00);
        idle(2);
        chk("full_words", words_loaded, 256);
        chk("full_ok_cnt", ok_cnt, 3);
        rd_check("full_mem255", 8'd255, 16'hFF00);
        rd_check("full_mem0", 8'd0, 16'h00FF);
        rd_check("full_mem128", 8'd128, 16'h807F);
        send_list('{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h4A});
        idle(2);
        chk("sync_data_words", words_loaded, 1);
        chk("sync_data_ok_cnt", ok_cnt, 4);
        rd_check("sync_data_mem0", 8'd0, 16'hA5A5);
        send_list('{8'hA5, 8'h02, 8'h11});
        chk("mid_loading", loading, 1);
        do_reset();
        idle(2);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_load_err", load_err, 0);
        chk("abort_loading", loading, 0);
        chk("abort_words", words_loaded, 0);
        rd_check("abort_mem0", 8'd0, 16'hA5A5);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
